// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the up/down counter slice:
//   DIR_UP / DIR_DOWN  - encodings of the UP direction input
//   WIDTH_MIN/MAX      - legal range of the counter width parameter
//   max_count()        - largest value representable in a given width
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Evaluated in 64 bits so that a 32-bit counter does not overflow.
  function automatic longint unsigned max_count(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/updown_register.sv
// updown_register
// WIDTH-bit state register for the up/down counter.
// Ports:
//   clk    - rising-edge clock
//   resetn - synchronous active-low reset, loads INIT
//   en     - capture enable; q holds when low
//   d      - next-state value
//   q      - registered state
module updown_register #(
  parameter int              WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset takes priority over the enable so that a reset lands even
  // while the counter is idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= INIT;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// updown_counter
// Loadable up/down counter with terminal count 0..MAX and carry output.
// Build option: define UPDOWN_COUNTER_SATURATE_EN to make the counter stop
// at MAX (up) or 0 (down) instead of wrapping.
// Ports:
//   CLK    - rising-edge clock
//   RESETN - synchronous active-low reset, count returns to INIT
//   CE     - count enable
//   UP     - direction, DIR_UP increments, DIR_DOWN decrements
//   LD     - synchronous load of D (clamped to MAX), overrides CE
//   D      - load value
//   O      - registered count, never above MAX
//   COUT   - combinational terminal-count indication
module updown_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH = 4,
  parameter longint unsigned MAX   = max_count(WIDTH),
  parameter longint unsigned INIT  = 0
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);

  // Illegal parameter combinations stop elaboration.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("updown_counter: WIDTH out of range");
  end
  if (MAX < 1 || MAX > max_count(WIDTH)) begin : g_bad_max
    $error("updown_counter: MAX out of range for WIDTH");
  end
  if (INIT > MAX) begin : g_bad_init
    $error("updown_counter: INIT greater than MAX");
  end

  localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_V = INIT[WIDTH-1:0];

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] next_count;
  logic             at_max;
  logic             at_zero;
  logic             reg_en;

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);

  // The register only needs to capture when loading or counting.
  assign reg_en = LD | CE;

  // Next count: load (clamped) beats counting; the boundary behaviour
  // at MAX/0 is either wrap-around or saturation depending on the build.
  always_comb begin
    next_count = count;
    if (LD) begin
      next_count = (D > MAX_V) ? MAX_V : D;
    end else if (UP == DIR_UP) begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
      next_count = at_max ? MAX_V : count + 1'b1;
`else
      next_count = at_max ? '0 : count + 1'b1;
`endif
    end else begin
`ifdef UPDOWN_COUNTER_SATURATE_EN
      next_count = at_zero ? '0 : count - 1'b1;
`else
      next_count = at_zero ? MAX_V : count - 1'b1;
`endif
    end
  end

  updown_register #(
    .WIDTH (WIDTH),
    .INIT  (INIT_V)
  ) u_state (
    .clk    (CLK),
    .resetn (RESETN),
    .en     (reg_en),
    .d      (next_count),
    .q      (count)
  );

  assign O = count;

  // Gated by RESETN so a reset cycle never reports a terminal count.
  assign COUT = RESETN & CE & ~LD &
                (((UP == DIR_UP) & at_max) | ((UP == DIR_DOWN) & at_zero));

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter
// Directed bench for updown_counter (WIDTH=4, MAX=9). A second instance
// with INIT=3 shares all inputs to check the reset value. A behavioural
// model is compared against both instances every cycle, and directed
// sequences carry literal expectations.
module tb_updown_counter;
  import counter_pkg::*;

  localparam int W      = 4;
  localparam int MAXV   = 9;
`ifdef UPDOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         ce = 1'b0;
  logic         up = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] o, o3;
  logic         cout, cout3;

  int n_pass  = 0;
  int n_total = 0;

  int exp_o  = 0;
  int exp_o3 = 3;
  bit model_valid = 1'b0;

  updown_counter #(.WIDTH(W), .MAX(MAXV), .INIT(0)) dut (
    .CLK(clk), .RESETN(resetn), .CE(ce), .UP(up), .LD(ld), .D(d),
    .O(o), .COUT(cout)
  );

  updown_counter #(.WIDTH(W), .MAX(MAXV), .INIT(3)) dut_init3 (
    .CLK(clk), .RESETN(resetn), .CE(ce), .UP(up), .LD(ld), .D(d),
    .O(o3), .COUT(cout3)
  );

  always #5 clk = ~clk;

  // Counting modulo MAX+1, or clamped in the saturating build.
  function automatic int model_next(input int cur, input bit l_ce,
                                    input bit l_up, input bit l_ld,
                                    input int l_d);
    if (l_ld) return (l_d > MAXV) ? MAXV : l_d;
    if (!l_ce) return cur;
    if (l_up) begin
      if (SAT) return (cur + 1 > MAXV) ? MAXV : cur + 1;
      return (cur + 1) % (MAXV + 1);
    end
    if (SAT) return (cur == 0) ? 0 : cur - 1;
    return (cur + MAXV) % (MAXV + 1);
  endfunction

  function automatic bit model_cout(input int cur);
    if (!resetn || !ce || ld) return 1'b0;
    return up ? (cur == MAXV) : (cur == 0);
  endfunction

  task automatic checkValue(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      exp_o  = 0;
      exp_o3 = 3;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_o  = model_next(exp_o,  ce, up, ld, int'(d));
      exp_o3 = model_next(exp_o3, ce, up, ld, int'(d));
    end
  end

  // Inputs change 2 time units after the rising edge, so the falling edge
  // sees stable inputs and settled outputs.
  always @(negedge clk) begin
    if (model_valid) begin
      checkValue("model_o",     int'(o),     exp_o);
      checkValue("model_cout",  int'(cout),  int'(model_cout(exp_o)));
      checkValue("model_o3",    int'(o3),    exp_o3);
      checkValue("model_cout3", int'(cout3), int'(model_cout(exp_o3)));
    end
  end

  task automatic applyStimulus(input logic rn, input logic c, input logic u,
                               input logic l, input logic [W-1:0] dv);
    @(posedge clk);
    #2;
    resetn = rn;
    ce     = c;
    up     = u;
    ld     = l;
    d      = dv;
    #1;
  endtask

  task automatic checkOutput(input string name, input int exp_val, input int exp_c);
    checkValue({name, "_o"},    int'(o),    exp_val);
    checkValue({name, "_cout"}, int'(cout), exp_c);
  endtask

  initial begin
    int seq_dn[7];
    int pat_up[4];
    int exp_ud[4];

    // Reset then count up through the wrap.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("reset", 0, 0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
      if (SAT) checkOutput("count_up", (i > 9) ? 9 : i, (i >= 9) ? 1 : 0);
      else     checkOutput("count_up", i % 10, (i == 9) ? 1 : 0);
    end

    // Load 5 then count down through the wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    checkValue("load5_cout", int'(cout), 0);
    if (SAT) seq_dn = '{5, 4, 3, 2, 1, 0, 0};
    else     seq_dn = '{5, 4, 3, 2, 1, 0, 9};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b1, DIR_DOWN, 1'b0, 4'd0);
      checkOutput("count_down", seq_dn[i], (seq_dn[i] == 0) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("down_end", SAT ? 0 : 8, 0);

    // Load clamp, then load overriding a count enable at MAX.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd14);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b1, 4'd3);
    checkOutput("clamp_ld_wins", 9, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("ld_over_ce", 3, 0);

    // Reset in the middle of counting.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd7);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("from7", 7, 0);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("from7_b", 8, 0);
    applyStimulus(1'b0, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("reset_cout", 9, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("mid_reset", 0, 0);
    checkValue("init3_o", int'(o3), 3);

    // Hold with CE low, then toggle direction every cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, DIR_UP, 1'b0, 4'd0);
      checkOutput("hold", 4, 0);
    end
    pat_up = '{1, 0, 1, 0};
    exp_ud = '{4, 5, 4, 5};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, pat_up[i][0], 1'b0, 4'd0);
      checkOutput("toggle", exp_ud[i], 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("toggle_end", 4, 0);

    // Boundary behaviour at MAX and at 0 (wrap or saturate).
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd8);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("top_a", 8, 0);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("top_b", 9, 1);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("top_c", SAT ? 9 : 0, SAT ? 1 : 0);
    applyStimulus(1'b1, 1'b1, DIR_UP, 1'b0, 4'd0);
    checkOutput("top_d", SAT ? 9 : 1, SAT ? 1 : 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("top_end", SAT ? 9 : 2, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    applyStimulus(1'b1, 1'b1, DIR_DOWN, 1'b0, 4'd0);
    checkOutput("bot_a", 1, 0);
    applyStimulus(1'b1, 1'b1, DIR_DOWN, 1'b0, 4'd0);
    checkOutput("bot_b", 0, 1);
    applyStimulus(1'b1, 1'b1, DIR_DOWN, 1'b0, 4'd0);
    checkOutput("bot_c", SAT ? 0 : 9, SAT ? 1 : 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checkOutput("bot_end", SAT ? 0 : 8, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (2..32).
REQ-002 SHALL have parameter MAX, default 2**WIDTH-1, terminal count value (1..2**WIDTH-1).
REQ-003 SHALL have parameter INIT, default 0, reset value of the count (0..MAX).
REQ-004 SHALL use one clock and a synchronous, active-low reset.
REQ-005 SHALL have port CLK, input, 1, rising-edge clock for all state.
REQ-006 SHALL have port RESETN, input, 1, synchronous active-low reset.
REQ-007 SHALL have port CE, input, 1, count enable.
REQ-008 SHALL have port UP, input, 1, direction (1 = increment, 0 = decrement).
REQ-009 SHALL have port LD, input, 1, synchronous load strobe.
REQ-010 SHALL have port D, input, WIDTH, load value.
REQ-011 SHALL have port O, output, WIDTH, registered count.
REQ-012 SHALL have port COUT, output, 1, terminal-count/carry indication.

Function
REQ-013 SHALL evaluate on each CLK rising edge with priority: RESETN low, then LD, then CE, then hold.
REQ-014 SHALL, on LD=1, set O to D next cycle; D>MAX SHALL load MAX (clamp); CE and UP are ignored.
REQ-015 SHALL, on CE=1 with UP=1, set O to O+1, or to 0 when O==MAX (wrap).
REQ-016 SHALL, on CE=1 with UP=0, set O to O-1, or to MAX when O==0 (wrap).
REQ-017 SHALL hold O when CE=0 and LD=0.
REQ-018 SHALL drive COUT combinationally as CE & ~LD & ((UP & O==MAX) | (~UP & O==0)); COUT is 0 in any cycle where RESETN is low.
REQ-019 SHALL assert COUT for exactly one cycle per wrap when CE is held high (O is latency 1 from CE; COUT is latency 0).
REQ-020 SHALL never present an O value greater than MAX.
REQ-021 SHALL take effect immediately on a UP change while CE=1; the next step uses the new direction with no dead cycle.

Reset
REQ-022 SHALL set O to INIT on the first CLK edge sampling RESETN=0, including mid-count or mid-load.
REQ-023 SHALL hold O at INIT and COUT at 0 while RESETN stays low; counting resumes on the first edge sampling RESETN=1.

Configuration
REQ-024 SHALL, when UPDOWN_COUNTER_SATURATE_EN is defined, saturate instead of wrap: up at MAX holds MAX, down at 0 holds 0; COUT is still asserted per REQ-018.
REQ-025 SHALL, without UPDOWN_COUNTER_SATURATE_EN, wrap per REQ-015/REQ-016.

Structure
REQ-026 SHALL place direction encodings (DIR_UP=1, DIR_DOWN=0) and parameter-range check constants in shared package counter_pkg.
REQ-027 SHALL implement the state register as one sub-module, updown_register (WIDTH-bit flop bank with sync active-low reset to INIT, clock enable, and D input); next-state and terminal logic remain in updown_counter.
REQ-028 SHALL flag illegal parameters (INIT>MAX, MAX>2**WIDTH-1) at elaboration.

Verification (WIDTH=4, MAX=9, INIT=0 unless stated)
REQ-029 SHALL cover: RESETN=0 for 2 cycles then CE=1, UP=1 for 12 cycles -> O: 0,1..9,0,1; COUT=1 only while O==9.
REQ-030 SHALL cover: LD=1, D=5 then CE=1, UP=0 for 7 cycles -> O: 5,4,3,2,1,0,9,8; COUT=1 only while O==0.
REQ-031 SHALL cover: LD=1, D=14 -> O=9; LD=1 with CE=1 the same cycle -> load wins, COUT=0.
REQ-032 SHALL cover: counting from 7, RESETN=0 for one cycle -> O=0 next cycle, COUT=0 in that cycle; with INIT=3 -> O=3.
REQ-033 SHALL cover: with UPDOWN_COUNTER_SATURATE_EN, up from 8 for 4 cycles -> O: 9,9,9 with COUT=1 at 9; down from 1 -> O: 0,0 with COUT=1.
REQ-034 SHALL cover: CE=0 for 5 cycles at O=4 -> O stays 4, COUT=0; toggling UP each cycle from 4 -> O: 5,4,5,4.
